controle_sr_drive: RTL and testbench

Control stage directly upstream of the microwave magnetron SR latch (latch_SR). It debounces the START, STOP and DOOR_CLOSED front-panel inputs and accepts TIMER_DONE from the cooking timer. It runs a small FSM and emits single-cycle S and R pulses that set and clear the latch. It guarantees S and R are never both 1, so the latch never sees its forbidden input.

---
 rtl/controle_sr_drive_pkg.sv | 12 +
 rtl/controle_sr_drive_if.sv | 21 ++
 rtl/controle_sr_drive_debounce.sv | 33 +++
 rtl/controle_sr_drive.sv | 68 ++++++
 tb/tb_controle_sr_drive.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/controle_sr_drive_pkg.sv
// Shared types and constants for the magnetron SR-latch drive controller.
// State encoding doubles as the COOKING flag value.
package controle_sr_drive_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COOKING = 1'b1
    } state_e;

    localparam int DEB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/controle_sr_drive_if.sv
// Front-panel inputs and latch-drive outputs of controle_sr_drive.
// The master side drives the panel/timer; the slave side is the controller.
interface controle_sr_drive_if;
    logic START;
    logic STOP;
    logic DOOR_CLOSED;
    logic TIMER_DONE;
    logic S;
    logic R;
    logic COOKING;

    modport master (
        output START, STOP, DOOR_CLOSED, TIMER_DONE,
        input  S, R, COOKING
    );

    modport slave (
        input  START, STOP, DOOR_CLOSED, TIMER_DONE,
        output S, R, COOKING
    );
endinterface

// File: rtl/controle_sr_drive_debounce.sv
// Counter debouncer: the output follows the raw input only after DEB_CYCLES
// consecutive disagreeing samples; any agreeing sample restarts the count.
module controle_sr_drive_debounce
    import controle_sr_drive_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic OUT
);
    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       db_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= 8'd0;
            db_q  <= 1'b0;
        end else if (IN == db_q) begin
            cnt_q <= 8'd0;
        end else if (cnt_q == CNT_LAST) begin
            db_q  <= IN;
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign OUT = db_q;
endmodule

// File: rtl/controle_sr_drive.sv
// Debounced front-panel FSM producing single-cycle S/R pulses for the
// magnetron SR latch; S and R are never asserted together.
module controle_sr_drive
    import controle_sr_drive_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    controle_sr_drive_if.slave   bus
);
    logic   db_start, db_stop, db_door;
    logic   db_start_q, db_stop_q;
    logic   start_rise, stop_rise;
    state_e state_q;
    logic   s_q, r_q, cooking_q;

    controle_sr_drive_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .CLK(CLK), .RST(RST), .IN(bus.START), .OUT(db_start)
    );
    controle_sr_drive_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .CLK(CLK), .RST(RST), .IN(bus.STOP), .OUT(db_stop)
    );
    controle_sr_drive_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_door (
        .CLK(CLK), .RST(RST), .IN(bus.DOOR_CLOSED), .OUT(db_door)
    );

    assign start_rise = db_start & ~db_start_q;
    assign stop_rise  = db_stop  & ~db_stop_q;

    // R is held high throughout reset so the latch is cleared while RST is up.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            s_q        <= 1'b0;
            r_q        <= 1'b1;
            cooking_q  <= 1'b0;
            db_start_q <= 1'b0;
            db_stop_q  <= 1'b0;
        end else begin
            db_start_q <= db_start;
            db_stop_q  <= db_stop;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_rise && db_door && !bus.TIMER_DONE && !stop_rise) begin
                        s_q       <= 1'b1;
                        cooking_q <= 1'b1;
                        state_q   <= ST_COOKING;
                    end
                end
                ST_COOKING: begin
                    if (stop_rise || !db_door || bus.TIMER_DONE) begin
                        r_q       <= 1'b1;
                        cooking_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.S       = s_q;
    assign bus.R       = r_q;
    assign bus.COOKING = cooking_q;
endmodule

// File: tb/tb_controle_sr_drive.sv
// Directed-vector bench for controle_sr_drive with DEB_CYCLES = 4.
// Every cycle also checks that S and R are exclusive and that S implies COOKING.
module tb_controle_sr_drive;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    controle_sr_drive_if bus ();

    controle_sr_drive #(.DEB_CYCLES(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge, then check the outputs against the expected triple.
    task automatic run_n(input string tag, input int n, input logic s, input logic r, input logic c);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, ".S"}, 8'(bus.S), 8'(s));
            chk({tag, ".R"}, 8'(bus.R), 8'(r));
            chk({tag, ".COOKING"}, 8'(bus.COOKING), 8'(c));
            chk({tag, ".s_and_r"}, 8'(bus.S & bus.R), 8'd0);
            chk({tag, ".s_no_cook"}, 8'(bus.S & ~bus.COOKING), 8'd0);
        end
    endtask

    // Clean press and release of START with the door debounced closed, from IDLE.
    task automatic press_start(input string tag);
        bus.START = 1'b1;
        run_n({tag, ".deb"}, 4, 1'b0, 1'b0, 1'b0);
        run_n({tag, ".set"}, 1, 1'b1, 1'b0, 1'b1);
        bus.START = 1'b0;
        run_n({tag, ".hold"}, 5, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.START       = 1'b0;
        bus.STOP        = 1'b0;
        bus.DOOR_CLOSED = 1'b0;
        bus.TIMER_DONE  = 1'b0;
        RST             = 1'b1;

        run_n("reset", 2, 1'b0, 1'b1, 1'b0);
        RST = 1'b0;
        run_n("rst_release", 1, 1'b0, 1'b0, 1'b0);

        // Normal start with START held six cycles.
        bus.DOOR_CLOSED = 1'b1;
        run_n("door_deb", 6, 1'b0, 1'b0, 1'b0);
        bus.START = 1'b1;
        run_n("start_deb", 4, 1'b0, 1'b0, 1'b0);
        run_n("start_set", 1, 1'b1, 1'b0, 1'b1);
        run_n("start_held", 1, 1'b0, 1'b0, 1'b1);
        bus.START = 1'b0;
        run_n("start_rel", 5, 1'b0, 1'b0, 1'b1);

        // Stop with the same latency.
        bus.STOP = 1'b1;
        run_n("stop_deb", 4, 1'b0, 1'b0, 1'b1);
        run_n("stop_clr", 1, 1'b0, 1'b1, 1'b0);
        run_n("stop_after", 1, 1'b0, 1'b0, 1'b0);
        bus.STOP = 1'b0;
        run_n("stop_rel", 5, 1'b0, 1'b0, 1'b0);

        // Bouncing START never debounces.
        for (int k = 0; k < 6; k++) begin
            bus.START = (k % 2 == 0);
            run_n("bounce", 1, 1'b0, 1'b0, 1'b0);
        end
        bus.START = 1'b0;
        run_n("bounce_tail", 4, 1'b0, 1'b0, 1'b0);

        // Door opening while cooking, then START with door open.
        press_start("door_run");
        bus.DOOR_CLOSED = 1'b0;
        run_n("door_open_deb", 4, 1'b0, 1'b0, 1'b1);
        run_n("door_open_clr", 1, 1'b0, 1'b1, 1'b0);
        run_n("door_open_after", 2, 1'b0, 1'b0, 1'b0);
        bus.START = 1'b1;
        run_n("start_door_open", 8, 1'b0, 1'b0, 1'b0);
        bus.START = 1'b0;
        run_n("start_door_rel", 5, 1'b0, 1'b0, 1'b0);

        // Timer expiry: one-edge latency to R.
        bus.DOOR_CLOSED = 1'b1;
        run_n("door_close", 5, 1'b0, 1'b0, 1'b0);
        press_start("timer_run");
        bus.TIMER_DONE = 1'b1;
        run_n("timer_clr", 1, 1'b0, 1'b1, 1'b0);
        bus.TIMER_DONE = 1'b0;
        run_n("timer_after", 2, 1'b0, 1'b0, 1'b0);
        bus.TIMER_DONE = 1'b1;
        bus.START = 1'b1;
        run_n("start_timer_hi", 8, 1'b0, 1'b0, 1'b0);
        bus.START = 1'b0;
        run_n("start_timer_rel", 5, 1'b0, 1'b0, 1'b0);
        bus.TIMER_DONE = 1'b0;
        run_n("timer_low", 2, 1'b0, 1'b0, 1'b0);

        // START and STOP rising together in IDLE: stop dominates.
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        run_n("start_stop_same", 8, 1'b0, 1'b0, 1'b0);
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        run_n("start_stop_rel", 5, 1'b0, 1'b0, 1'b0);

        // START held through a stop must not re-trigger.
        bus.START = 1'b1;
        run_n("held_deb", 4, 1'b0, 1'b0, 1'b0);
        run_n("held_set", 1, 1'b1, 1'b0, 1'b1);
        run_n("held_run", 2, 1'b0, 1'b0, 1'b1);
        bus.STOP = 1'b1;
        run_n("held_stop_deb", 4, 1'b0, 1'b0, 1'b1);
        run_n("held_stop_clr", 1, 1'b0, 1'b1, 1'b0);
        bus.STOP = 1'b0;
        run_n("held_no_retrig", 8, 1'b0, 1'b0, 1'b0);
        bus.START = 1'b0;
        run_n("held_rel", 5, 1'b0, 1'b0, 1'b0);
        press_start("new_press");

        // Door opens and STOP pressed together: exactly one R pulse.
        bus.DOOR_CLOSED = 1'b0;
        bus.STOP        = 1'b1;
        run_n("door_stop_deb", 4, 1'b0, 1'b0, 1'b1);
        run_n("door_stop_clr", 1, 1'b0, 1'b1, 1'b0);
        run_n("door_stop_single", 3, 1'b0, 1'b0, 1'b0);
        bus.STOP        = 1'b0;
        bus.DOOR_CLOSED = 1'b1;
        run_n("door_stop_rel", 5, 1'b0, 1'b0, 1'b0);

        // Reset mid-cooking, then recovery after the door re-debounces.
        press_start("rst_run");
        RST = 1'b1;
        run_n("rst_mid", 1, 1'b0, 1'b1, 1'b0);
        RST = 1'b0;
        run_n("rst_mid_rel", 1, 1'b0, 1'b0, 1'b0);
        run_n("rst_door_deb", 4, 1'b0, 1'b0, 1'b0);
        press_start("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
